// File: rtl/des_key_sched.sv
// DES / 3DES round-subkey generator streaming 48-bit subkeys over a valid/ready handshake.
// Optional key parity checking is enabled by defining KS_PARITY_CHK_EN.
module des_key_sched #(
   parameter int NKEYS = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 key_valid,
   output logic                 key_ready,
   input  logic [64*NKEYS-1:0]  key_in,
   input  logic                 decrypt,
   output logic                 sk_valid,
   input  logic                 sk_ready,
   output logic [47:0]          sk_data,
   output logic [3:0]           sk_round,
   output logic [1:0]           sk_stage,
   output logic                 sk_last,
   output logic                 parity_err
);

   generate
      if (NKEYS < 1 || NKEYS > 3) begin : g_bad_nkeys
         $error("des_key_sched: NKEYS must be 1, 2 or 3");
      end
   endgenerate

   localparam int NSTAGES = (NKEYS == 1) ? 1 : 3;
   localparam logic [1:0] LAST_STAGE = 2'(NSTAGES - 1);

   localparam int PC1_TAB [56] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

   localparam int PC2_TAB [48] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

   // Tables use DES numbering: position 1 is the MSB of the vector.
   function automatic logic [55:0] perm_pc1(input logic [63:0] k);
      logic [55:0] r;
      r = '0;
      for (int i = 0; i < 56; i++) r[6'(55 - i)] = k[6'(64 - PC1_TAB[i])];
      return r;
   endfunction

   function automatic logic [47:0] perm_pc2(input logic [55:0] cd);
      logic [47:0] r;
      r = '0;
      for (int i = 0; i < 48; i++) r[6'(47 - i)] = cd[6'(56 - PC2_TAB[i])];
      return r;
   endfunction

   function automatic logic [1:0] shift_amt(input logic [3:0] r);
      return (r == 4'd0 || r == 4'd1 || r == 4'd8 || r == 4'd15) ? 2'd1 : 2'd2;
   endfunction

   function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] n);
      return (n == 2'd2) ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
   endfunction

   function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] n);
      return (n == 2'd2) ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
   endfunction

   typedef enum logic [1:0] {IDLE, PC1, GEN} state_t;
   state_t state, state_nxt;

   logic [64*NKEYS-1:0] key_q;
   logic                dec_q;
   logic [27:0]         c_q, d_q;
   logic [3:0]          round_q;
   logic [1:0]          stage_q, key_idx;
   logic [63:0]         k1, k2, k3, stage_key;
   logic [1:0]          shift_l, shift_r;
   logic [55:0]         cd_rotl, cd_rotr;
   logic                enc_sched, round_last, stage_last;

   // Missing keys alias K1, so NKEYS=2 gets K3=K1 and NKEYS=1 always picks K1.
   assign k1 = key_q[63:0];
   generate
      if (NKEYS >= 2) begin : g_k2
         assign k2 = key_q[127:64];
      end else begin : g_k2_dup
         assign k2 = k1;
      end
      if (NKEYS >= 3) begin : g_k3
         assign k3 = key_q[191:128];
      end else begin : g_k3_dup
         assign k3 = k1;
      end
   endgenerate

   always_comb begin
      key_idx = dec_q ? (2'd2 - stage_q) : stage_q;
      case (key_idx)
         2'd0:    stage_key = k1;
         2'd1:    stage_key = k2;
         default: stage_key = k3;
      endcase
   end

   assign enc_sched  = ~(stage_q[0] ^ dec_q);
   assign shift_l    = shift_amt(round_q);
   assign shift_r    = shift_amt(4'd15 - round_q);
   assign cd_rotl    = {rotl28(c_q, shift_l), rotl28(d_q, shift_l)};
   assign cd_rotr    = {rotr28(c_q, shift_r), rotr28(d_q, shift_r)};
   assign round_last = (round_q == 4'd15);
   assign stage_last = (stage_q == LAST_STAGE);

   // NOTE: every variable is given a default before the case, so no latch is inferred.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (key_valid) state_nxt = PC1;
         PC1:     state_nxt = GEN;
         GEN:     if (sk_ready && round_last) state_nxt = stage_last ? IDLE : PC1;
         default: state_nxt = IDLE;
      endcase
   end

   assign key_ready = (state == IDLE);
   assign sk_valid  = (state == GEN);
   assign sk_data   = sk_valid ? perm_pc2(enc_sched ? cd_rotl : {c_q, d_q}) : '0;
   assign sk_round  = round_q;
   assign sk_stage  = stage_q;
   assign sk_last   = sk_valid && round_last && stage_last;

   // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         c_q     <= '0;
         d_q     <= '0;
         round_q <= '0;
         stage_q <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: if (key_valid) begin
               stage_q <= '0;
               round_q <= '0;
            end
            PC1: begin
               {c_q, d_q} <= perm_pc1(stage_key);
               round_q    <= '0;
            end
            GEN: if (sk_ready) begin
               {c_q, d_q} <= enc_sched ? cd_rotl : cd_rotr;
               if (round_last) begin
                  round_q <= '0;
                  stage_q <= stage_last ? 2'd0 : stage_q + 2'd1;
               end else begin
                  round_q <= round_q + 4'd1;
               end
            end
            default: ;
         endcase
      end
   end

   // NOTE: key and direction are always loaded before they are read, so they carry no reset.
   always_ff @(posedge clk) begin
      if (key_ready && key_valid) begin
         key_q <= key_in;
         dec_q <= decrypt;
      end
   end

`ifdef KS_PARITY_CHK_EN
   logic [8*NKEYS-1:0] byte_ok;
   for (genvar g = 0; g < 8 * NKEYS; g++) begin : g_par
      assign byte_ok[g] = ^key_in[8*g +: 8];
   end

   always_ff @(posedge clk) begin
      if (rst) parity_err <= 1'b0;
      else if (key_ready && key_valid) parity_err <= ~&byte_ok;
   end
`else
   assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_des_key_sched.sv
// Directed bench for des_key_sched: NKEYS=1 and NKEYS=3 instances, known-answer subkeys,
// stalls, inter-stage bubbles, busy key offers, mid-schedule reset and parity flag.
module tb_des_key_sched;

   localparam logic [63:0] KEY_GOOD = 64'h133457799BBCDFF1;
   localparam logic [63:0] KEY_BAD  = 64'h133457799BBCDFF0;
`ifdef KS_PARITY_CHK_EN
   localparam bit PAR_ON = 1'b1;
`else
   localparam bit PAR_ON = 1'b0;
`endif

   // Encrypt-order subkeys K1..K16 of KEY_GOOD (parity bits do not affect them).
   localparam logic [47:0] KTAB [16] = '{
      48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
      48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
      48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
      48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5};

   typedef struct {
      bit          sel3;
      bit          dec;
      bit          rnd;
      logic [63:0] key;
      logic [47:0] exp_first;
      logic [47:0] exp_final;
      int          exp_busy;
      bit          exp_par;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst, kv, dec, rdy, dut_sel;
   logic [191:0] key3;

   logic        kr1, v1, l1, pe1, kr3, v3, l3, pe3;
   logic [47:0] d1, d3;
   logic [3:0]  r1, r3;
   logic [1:0]  s1, s3;

   des_key_sched #(.NKEYS(1)) u_dut1 (
      .clk(clk), .rst(rst), .key_valid(kv & ~dut_sel), .key_ready(kr1),
      .key_in(key3[63:0]), .decrypt(dec), .sk_valid(v1), .sk_ready(rdy),
      .sk_data(d1), .sk_round(r1), .sk_stage(s1), .sk_last(l1), .parity_err(pe1));

   des_key_sched #(.NKEYS(3)) u_dut3 (
      .clk(clk), .rst(rst), .key_valid(kv & dut_sel), .key_ready(kr3),
      .key_in(key3), .decrypt(dec), .sk_valid(v3), .sk_ready(rdy),
      .sk_data(d3), .sk_round(r3), .sk_stage(s3), .sk_last(l3), .parity_err(pe3));

   logic        cur_kr, cur_v, cur_l, cur_pe;
   logic [47:0] cur_d;
   logic [3:0]  cur_r;
   logic [1:0]  cur_s;
   assign cur_kr = dut_sel ? kr3 : kr1;
   assign cur_v  = dut_sel ? v3  : v1;
   assign cur_l  = dut_sel ? l3  : l1;
   assign cur_pe = dut_sel ? pe3 : pe1;
   assign cur_d  = dut_sel ? d3  : d1;
   assign cur_r  = dut_sel ? r3  : r1;
   assign cur_s  = dut_sel ? s3  : s1;

   int checks = 0;
   int errors = 0;
   vec_t vecs [7];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   function automatic logic [47:0] model_sk(input int stage, input int round, input bit d);
      bit enc;
      enc = (((stage % 2) != 0) ^ d) == 1'b0;
      return enc ? KTAB[round] : KTAB[15 - round];
   endfunction

   task automatic run_vec(input vec_t v, input int n);
      int c, n_xfer, busy, bubbles, c_first, c_last, c_ready, nstages, exp_stage, exp_round;
      bit stalled, done, exp_last;
      logic [54:0] held, now;
      logic [47:0] first_sk, final_sk;
      nstages = v.sel3 ? 3 : 1;
      c = 0; n_xfer = 0; busy = 0; bubbles = 0;
      c_first = -1; c_last = -1; c_ready = -1;
      exp_stage = 0; exp_round = 0; stalled = 0; done = 0;
      held = '0; first_sk = '0; final_sk = '0;
      @(negedge clk);
      dut_sel = v.sel3; dec = v.dec; key3 = {3{v.key}}; rdy = 1'b1; kv = 1'b1;
      #1;
      check($sformatf("v%0d_key_ready_idle", n), 64'(cur_kr), 64'd1);
      @(posedge clk);
      while (!done && c < 1000) begin
         @(negedge clk);
         c++;
         // A key offered while busy must be ignored.
         kv = (c == 5);
         key3 = (c == 5) ? ~{3{v.key}} : {3{v.key}};
         dec  = (c == 5) ? ~v.dec : v.dec;
         rdy  = v.rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
         #1;
         now = {cur_d, cur_r, cur_s, cur_l};
         if (stalled)
            check($sformatf("v%0d_stall_hold_c%0d", n, c), 64'({cur_v, now}), 64'({1'b1, held}));
         if (cur_kr) begin
            c_ready = c;
            done = 1;
         end else begin
            busy++;
            if (!cur_v && c_first >= 0) bubbles++;
            if (cur_v && c_first < 0) c_first = c;
            if (cur_v && rdy) begin
               exp_last = (exp_round == 15) && (exp_stage == nstages - 1);
               check($sformatf("v%0d_xfer_s%0d_r%0d", n, exp_stage, exp_round), 64'(now),
                     64'({model_sk(exp_stage, exp_round, v.dec), 4'(exp_round), 2'(exp_stage), exp_last}));
               if (n_xfer == 0) first_sk = cur_d;
               final_sk = cur_d;
               c_last = c;
               n_xfer++;
               if (exp_round == 15) begin
                  exp_round = 0;
                  exp_stage++;
               end else begin
                  exp_round++;
               end
            end
            stalled = cur_v && !rdy;
            held = now;
         end
      end
      kv = 1'b0; rdy = 1'b1;
      check($sformatf("v%0d_returned_idle", n), 64'(done), 64'd1);
      check($sformatf("v%0d_first_valid_cycle", n), 64'(c_first), 64'd2);
      check($sformatf("v%0d_xfer_count", n), 64'(n_xfer), 64'(16 * nstages));
      check($sformatf("v%0d_ready_after_last", n), 64'(c_ready), 64'(c_last + 1));
      check($sformatf("v%0d_bubbles", n), 64'(bubbles), 64'(nstages - 1));
      check($sformatf("v%0d_first_subkey", n), 64'(first_sk), 64'(v.exp_first));
      check($sformatf("v%0d_final_subkey", n), 64'(final_sk), 64'(v.exp_final));
      if (v.exp_busy > 0)
         check($sformatf("v%0d_busy_cycles", n), 64'(busy), 64'(v.exp_busy));
      check($sformatf("v%0d_parity_err", n), 64'(cur_pe), 64'(v.exp_par));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit found;
      int late_valid;
      //           sel3  dec   rnd   key       first             final             busy exp_par
      vecs[0] = '{1'b0, 1'b0, 1'b0, KEY_GOOD, 48'h1B02EFFC7072, 48'hCB3D8B0E17F5, 17, 1'b0};
      vecs[1] = '{1'b0, 1'b1, 1'b0, KEY_GOOD, 48'hCB3D8B0E17F5, 48'h1B02EFFC7072, 17, 1'b0};
      vecs[2] = '{1'b1, 1'b0, 1'b0, KEY_GOOD, 48'h1B02EFFC7072, 48'hCB3D8B0E17F5, 51, 1'b0};
      vecs[3] = '{1'b1, 1'b1, 1'b0, KEY_GOOD, 48'hCB3D8B0E17F5, 48'h1B02EFFC7072, 51, 1'b0};
      vecs[4] = '{1'b1, 1'b0, 1'b1, KEY_GOOD, 48'h1B02EFFC7072, 48'hCB3D8B0E17F5, 0,  1'b0};
      vecs[5] = '{1'b0, 1'b1, 1'b1, KEY_BAD,  48'hCB3D8B0E17F5, 48'h1B02EFFC7072, 0,  PAR_ON};
      vecs[6] = '{1'b0, 1'b0, 1'b0, KEY_GOOD, 48'h1B02EFFC7072, 48'hCB3D8B0E17F5, 17, 1'b0};

      rst = 1'b1; kv = 1'b0; dec = 1'b0; rdy = 1'b0; dut_sel = 1'b0; key3 = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_key_ready_1", 64'(kr1), 64'd1);
      check("rst_outputs_1", 64'({v1, d1, r1, s1, l1, pe1}), 64'd0);
      check("rst_key_ready_3", 64'(kr3), 64'd1);
      check("rst_outputs_3", 64'({v3, d3, r3, s3, l3, pe3}), 64'd0);

      for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

      // Reset in the middle of stage 1 aborts the schedule.
      @(negedge clk);
      dut_sel = 1'b1; dec = 1'b0; key3 = {3{KEY_GOOD}}; rdy = 1'b1; kv = 1'b1;
      @(negedge clk);
      kv = 1'b0;
      found = 0;
      for (int i = 0; i < 200 && !found; i++) begin
         if (cur_v && cur_s == 2'd1 && cur_r == 4'd7) found = 1;
         else @(negedge clk);
      end
      check("rst_reach_s1_r7", 64'(found), 64'd1);
      rst = 1'b1;
      @(negedge clk);
      check("rst_abort_outputs", 64'({cur_v, cur_kr, cur_d, cur_r, cur_s, cur_l}),
            64'({1'b0, 1'b1, 48'h0, 4'h0, 2'h0, 1'b0}));
      rst = 1'b0;
      late_valid = 0;
      repeat (3) begin
         @(negedge clk);
         if (cur_v) late_valid++;
      end
      check("rst_no_late_subkeys", 64'(late_valid), 64'd0);
      run_vec(vecs[2], 7);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
